// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//   8N1 UART receiver (8E1/8O1 when UART_RX_PARITY_EN is defined).
//   Synchronises the asynchronous line, finds the start bit, samples every
//   bit in the middle of its cell and hands received bytes to a consumer
//   over a valid/ready handshake. Framing errors, overruns and (optionally)
//   parity errors are reported as single-cycle pulses.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   : frame = start, 8 data, parity, stop; rx_parity_err exists
//     undefined : 8N1 only, PARITY_ODD has no effect
//
// Parameters
//   CLK_FREQ    clock frequency in Hz
//   BAUD        line rate in bit/s
//   PARITY_ODD  0 = even parity, 1 = odd parity (parity build only)
//
// Ports
//   clk            in   system clock
//   reset_         in   asynchronous active-low reset
//   uart_rx        in   serial line, idle high, asynchronous to clk
//   rx_req         out  rx_data valid
//   rx_ready       in   consumer accepts; transfer on rx_req && rx_ready
//   rx_data[7:0]   out  received byte (LSB first on the line)
//   rx_frame_err   out  1-cycle pulse: stop bit sampled low
//   rx_overrun     out  1-cycle pulse: byte completed while holding reg full
//   rx_parity_err  out  1-cycle pulse: parity mismatch (parity build only)
// ---------------------------------------------------------------------------
module uart_rx_core #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       uart_rx,
    output logic       rx_req,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    output logic       rx_overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       rx_parity_err
`endif
);

    localparam int DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_e;

    // ---------------------------------------------------------------
    // Two-flop synchroniser; everything downstream looks only at rxs.
    // ---------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rxs;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], uart_rx};
    end

    assign rxs = sync_q[1];

    // ---------------------------------------------------------------
    // Bit timer. While idle it is kept armed at HALF-1 so the first tick
    // after the falling edge lands mid start bit; afterwards it ticks
    // once per bit cell.
    // ---------------------------------------------------------------
    state_e        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (state_q == S_IDLE) cnt_d = HALF_M1;
        else if (tick)         cnt_d = DIV_M1;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    // ---------------------------------------------------------------
    // Frame FSM, shift register, holding register and status pulses.
    // ---------------------------------------------------------------
    logic [2:0] bit_idx_q;
    logic [7:0] shreg_q;
    logic       rx_req_q;
    logic [7:0] rx_data_q;
    logic       frame_err_q;
    logic       overrun_q;
    logic       drop_par;
    logic       xfer;

    assign xfer = rx_req_q && rx_ready;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD_BIT = PARITY_ODD[0];
    logic par_bad_q;
    logic parity_err_q;
    assign drop_par      = par_bad_q;
    assign rx_parity_err = parity_err_q;
`else
    assign drop_par = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q      <= S_IDLE;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            rx_req_q     <= 1'b0;
            rx_data_q    <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // A delivery later in this cycle overrides the clear.
            if (xfer) rx_req_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!rxs) state_q <= S_START;
                end
                S_START: begin
                    if (tick) begin
                        // Line back high at mid start bit: treat as glitch.
                        if (rxs) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                            par_bad_q <= 1'b0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shreg_q   <= {rxs, shreg_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        par_bad_q <= (rxs != (^shreg_q ^ PAR_ODD_BIT));
                        state_q   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (rxs) begin
                            state_q <= S_IDLE;
                            if (drop_par) begin
`ifdef UART_RX_PARITY_EN
                                parity_err_q <= 1'b1;
`endif
                            end else if (!rx_req_q || xfer) begin
                                rx_data_q <= shreg_q;
                                rx_req_q  <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // Stay silent until the line is released.
                    if (rxs) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_req       = rx_req_q;
    assign rx_data      = rx_data_q;
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;

endmodule
